// File: rtl/jtag_uart_encode.sv
// Transmit encoder for the JTAG UART host link: buffers bytes/commands, applies the
// 0xFE escape protocol and writes the stream to the Avalon slave under WSPACE credit.
module jtag_uart_encode #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned POLL_GAP   = 32
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    output logic        oJTAG_SLAVE_ADDR,
    output logic        oJTAG_SLAVE_RDREQ,
    input  logic [31:0] iJTAG_SLAVE_RDDATA,
    output logic        oJTAG_SLAVE_WRREQ,
    output logic [31:0] oJTAG_SLAVE_WRDATA,
    input  logic        iJTAG_SLAVE_WAIT,
    input  logic [7:0]  iTX_DATA,
    input  logic        iTX_IS_CMD,
    input  logic        iTX_VALID,
    output logic        oTX_READY,
    output logic        oBUSY
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam logic [7:0]  ESC = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_BACKOFF,
        ST_WR1,
        ST_WR2
    } state_t;

    state_t        state;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          avail;
    logic [8:0]    head;
    logic          head_two;
    logic [15:0]   credit;
    logic [15:0]   credit_dec;
    logic [15:0]   wspace;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    hold_byte;
    logic          hold_two;
    logic          resume_wr2;
    logic          rd_accept;
    logic          wr_accept;
    logic          unused_rd_low;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = iTX_VALID && !full;
    assign pop   = (state == ST_IDLE) && avail;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_two   = head[8] || (head[7:0] == ESC);
    assign wspace     = iJTAG_SLAVE_RDDATA[31:16];
    assign credit_dec = (credit != '0) ? credit - 16'd1 : credit;
    assign rd_accept  = oJTAG_SLAVE_RDREQ && !iJTAG_SLAVE_WAIT;
    assign wr_accept  = oJTAG_SLAVE_WRREQ && !iJTAG_SLAVE_WAIT;

    assign unused_rd_low = ^iJTAG_SLAVE_RDDATA[15:0];

    assign oTX_READY = !full;
    assign oBUSY     = !empty || (state != ST_IDLE);

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {iTX_IS_CMD, iTX_DATA};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // avail lags the FIFO by one cycle; a pop always leaves ST_IDLE for at least one
    // cycle, so the flag has caught up before ST_IDLE looks at it again.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state              <= ST_IDLE;
            avail              <= 1'b0;
            credit             <= '0;
            gap_cnt            <= '0;
            hold_byte          <= '0;
            hold_two           <= 1'b0;
            resume_wr2         <= 1'b0;
            oJTAG_SLAVE_ADDR   <= 1'b0;
            oJTAG_SLAVE_RDREQ  <= 1'b0;
            oJTAG_SLAVE_WRREQ  <= 1'b0;
            oJTAG_SLAVE_WRDATA <= '0;
        end else begin
            avail <= !empty;
            case (state)
                ST_IDLE: begin
                    if (avail) begin
                        hold_byte  <= head[7:0];
                        hold_two   <= head_two;
                        resume_wr2 <= 1'b0;
                        if (credit != '0) begin
                            state              <= ST_WR1;
                            oJTAG_SLAVE_ADDR   <= 1'b0;
                            oJTAG_SLAVE_WRREQ  <= 1'b1;
                            oJTAG_SLAVE_WRDATA <= {24'd0, head_two ? ESC : head[7:0]};
                        end else begin
                            state             <= ST_POLL;
                            oJTAG_SLAVE_ADDR  <= 1'b1;
                            oJTAG_SLAVE_RDREQ <= 1'b1;
                        end
                    end
                end
                ST_POLL: begin
                    if (rd_accept) begin
                        credit            <= wspace;
                        oJTAG_SLAVE_RDREQ <= 1'b0;
                        oJTAG_SLAVE_ADDR  <= 1'b0;
                        if (wspace != '0) begin
                            state              <= resume_wr2 ? ST_WR2 : ST_WR1;
                            oJTAG_SLAVE_WRREQ  <= 1'b1;
                            oJTAG_SLAVE_WRDATA <= {24'd0, (resume_wr2 || !hold_two) ? hold_byte : ESC};
                        end else begin
                            state   <= ST_BACKOFF;
                            gap_cnt <= '0;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        state             <= ST_POLL;
                        oJTAG_SLAVE_ADDR  <= 1'b1;
                        oJTAG_SLAVE_RDREQ <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                ST_WR1: begin
                    if (wr_accept) begin
                        credit <= credit_dec;
                        if (hold_two) begin
                            if (credit > 16'd1) begin
                                state              <= ST_WR2;
                                oJTAG_SLAVE_WRDATA <= {24'd0, hold_byte};
                            end else begin
                                state             <= ST_POLL;
                                resume_wr2        <= 1'b1;
                                oJTAG_SLAVE_WRREQ <= 1'b0;
                                oJTAG_SLAVE_ADDR  <= 1'b1;
                                oJTAG_SLAVE_RDREQ <= 1'b1;
                            end
                        end else begin
                            state             <= ST_IDLE;
                            oJTAG_SLAVE_WRREQ <= 1'b0;
                        end
                    end
                end
                ST_WR2: begin
                    if (wr_accept) begin
                        credit            <= credit_dec;
                        state             <= ST_IDLE;
                        resume_wr2        <= 1'b0;
                        oJTAG_SLAVE_WRREQ <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
